// File: rtl/sprite_motion_pkg.sv
// sprite_pkg: shared widths and motion state encoding for the sprite controller
package sprite_pkg;
  localparam int CORDW = 16;
  localparam int ADDRW = 11;
  typedef enum logic [1:0] {GROUND = 2'd0, RISE = 2'd1, FALL = 2'd2} motion_state_t;
endpackage

// File: rtl/sprite_motion_if.sv
// sprite_motion_if: frame/control inputs and registered sprite outputs
interface sprite_motion_if;
  import sprite_pkg::*;
  logic i_frame;
  logic i_walk_en;
  logic i_jump_n;
  logic signed [CORDW-1:0] o_sprx;
  logic signed [CORDW-1:0] o_spry;
  logic [ADDRW-1:0] o_base_addr;
  logic o_airborne;
  logic [1:0] o_state;
  modport master (output i_frame, i_walk_en, i_jump_n, input o_sprx, o_spry, o_base_addr, o_airborne, o_state);
  modport slave (input i_frame, i_walk_en, i_jump_n, output o_sprx, o_spry, o_base_addr, o_airborne, o_state);
endinterface

// File: rtl/sprite_motion_key_sync_edge.sv
// key_sync_edge: 2-flop synchronizer plus falling-edge pulse for an active-low button
module key_sync_edge (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_key_n,
  output logic o_fall
);
  logic r_s0, r_s1, r_prev;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) {r_s0, r_s1, r_prev} <= 3'b111;
    else {r_s0, r_s1, r_prev} <= {i_key_n, r_s0, r_s1};
  assign o_fall = r_prev & ~r_s1;
endmodule

// File: rtl/sprite_motion.sv
// sprite_motion: per-frame walk, jump and animation-frame selection for a sprite
module sprite_motion
  import sprite_pkg::*;
#(
  parameter int SPR_PIXELS = 640,
  parameter int H_RES      = 800,
  parameter int WRAP_LEFT  = -132,
  parameter int SPEED_X    = 2,
  parameter int GROUND_Y   = 240,
  parameter int JUMP_V0    = 12,
  parameter int GRAVITY    = 1,
  parameter int ANIM_STEP  = 16
) (
  input logic i_clk,
  input logic i_rst_n,
  sprite_motion_if.slave bus
);
  localparam logic signed [CORDW-1:0] X0 = CORDW'(H_RES);
  localparam logic signed [CORDW-1:0] XL = CORDW'(WRAP_LEFT);
  localparam logic signed [CORDW-1:0] DX = CORDW'(SPEED_X);
  localparam logic signed [CORDW-1:0] Y0 = CORDW'(GROUND_Y);
  localparam logic [7:0] G = 8'(GRAVITY);
  localparam logic [ADDRW-1:0] B1 = ADDRW'(SPR_PIXELS);
  localparam logic [ADDRW-1:0] B2 = ADDRW'(2 * SPR_PIXELS);
  motion_state_t r_state, w_state;
  logic [7:0] r_vel, w_vel, w_v1;
  logic signed [CORDW-1:0] r_x, r_y, w_x, w_y, w_vel_s, w_ysum;
  logic [ADDRW-1:0] r_base, w_base;
  logic [5:0] r_cnt, w_cnt;
  logic r_req, r_air, w_fall;
  key_sync_edge u_key (.i_clk(i_clk), .i_rst_n(i_rst_n), .i_key_n(bus.i_jump_n), .o_fall(w_fall));
  assign w_v1 = r_vel + G;
  assign w_vel_s = CORDW'(r_vel);
  assign w_ysum = r_y + CORDW'(w_v1);
  always_comb begin
    w_state = r_state;
    w_vel = r_vel;
    w_y = r_y;
    w_base = r_base;
    w_cnt = r_cnt;
    w_x = !bus.i_walk_en ? r_x : (r_x > XL) ? r_x - DX : X0;
    case (r_state)
      GROUND: begin
        if (r_req) begin
          w_state = RISE;
          w_vel = 8'(JUMP_V0);
        end
        w_base = !bus.i_walk_en ? '0 :
                 r_cnt == '0 ? '0 :
                 r_cnt == 6'(ANIM_STEP - 1) ? B1 :
                 r_cnt == 6'(2 * ANIM_STEP - 1) ? '0 :
                 r_cnt == 6'(3 * ANIM_STEP - 1) ? B2 : r_base;
        w_cnt = bus.i_walk_en ? r_cnt + 6'd1 : r_cnt;
      end
      RISE: begin
        w_y = r_y - w_vel_s;
        w_base = B1;
        w_vel = (r_vel <= G) ? '0 : r_vel - G;
        w_state = (r_vel <= G) ? FALL : RISE;
      end
      default: begin
        w_base = B1;
        w_vel = w_v1;
        w_y = w_ysum;
        if (w_ysum >= Y0) begin
          w_y = Y0;
          w_vel = '0;
          w_state = GROUND;
          w_base = '0;
          w_cnt = '0;
        end
      end
    endcase
  end
  // a new press landing on a frame pulse must survive that frame's clear
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_req <= 1'b0;
    else r_req <= w_fall | (r_req & ~bus.i_frame);
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_state <= GROUND;
      r_vel <= '0;
      r_x <= X0;
      r_y <= Y0;
      r_base <= '0;
      r_cnt <= '0;
      r_air <= 1'b0;
    end else if (bus.i_frame) begin
      r_state <= w_state;
      r_vel <= w_vel;
      r_x <= w_x;
      r_y <= w_y;
      r_base <= w_base;
      r_cnt <= w_cnt;
      r_air <= w_state != GROUND;
    end
  assign bus.o_sprx = r_x;
  assign bus.o_spry = r_y;
  assign bus.o_base_addr = r_base;
  assign bus.o_airborne = r_air;
  assign bus.o_state = r_state;
endmodule

// File: tb/tb_sprite_motion.sv
// tb_sprite_motion: directed checks of walk, wrap, animation, jump and reset
module tb_sprite_motion;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int vec = 0;
  int miss = 0;
  sprite_motion_if bus();
  sprite_motion dut (.i_clk(clk), .i_rst_n(rst_n), .bus(bus.slave));
  always #5 clk = ~clk;

  task automatic frame();
    @(posedge clk); #1 bus.i_frame = 1'b1;
    @(posedge clk); #1 bus.i_frame = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
  endtask

  task automatic press();
    @(posedge clk); #1 bus.i_jump_n = 1'b0;
    repeat (5) @(posedge clk);
    #1 bus.i_jump_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #17;
    vec++; if (bus.o_sprx !== 16'sd800) begin miss++; $display("FAIL reset_x got %0d want 800", bus.o_sprx); end
    vec++; if (bus.o_spry !== 16'sd240) begin miss++; $display("FAIL reset_y got %0d want 240", bus.o_spry); end
    vec++; if (bus.o_base_addr !== 11'd0 || bus.o_state !== 2'd0 || bus.o_airborne !== 1'b0)
      begin miss++; $display("FAIL reset_misc got base=%0d st=%0d air=%0b want 0/0/0", bus.o_base_addr, bus.o_state, bus.o_airborne); end
    #5 rst_n = 1'b1;
  endtask

  task automatic test_anim();
    do_reset();
    bus.i_walk_en = 1'b1;
    for (int f = 1; f <= 65; f++) begin
      frame();
      if (f == 16) begin vec++; if (bus.o_base_addr !== 11'd640) begin miss++; $display("FAIL anim16 got %0d want 640", bus.o_base_addr); end end
      if (f == 32) begin vec++; if (bus.o_base_addr !== 11'd0) begin miss++; $display("FAIL anim32 got %0d want 0", bus.o_base_addr); end end
      if (f == 48) begin vec++; if (bus.o_base_addr !== 11'd1280) begin miss++; $display("FAIL anim48 got %0d want 1280", bus.o_base_addr); end end
      if (f == 64) begin vec++; if (bus.o_base_addr !== 11'd1280) begin miss++; $display("FAIL anim64 got %0d want 1280", bus.o_base_addr); end end
      if (f == 65) begin vec++; if (bus.o_base_addr !== 11'd0) begin miss++; $display("FAIL anim65 got %0d want 0", bus.o_base_addr); end end
    end
    vec++; if (bus.o_sprx !== 16'sd670) begin miss++; $display("FAIL anim_x got %0d want 670", bus.o_sprx); end
    bus.i_walk_en = 1'b0;
  endtask

  task automatic test_walk_wrap();
    do_reset();
    bus.i_walk_en = 1'b1;
    frame();
    vec++; if (bus.o_sprx !== 16'sd798) begin miss++; $display("FAIL walk1 got %0d want 798", bus.o_sprx); end
    repeat (465) frame();
    vec++; if (bus.o_sprx !== -16'sd132) begin miss++; $display("FAIL walk466 got %0d want -132", bus.o_sprx); end
    frame();
    vec++; if (bus.o_sprx !== 16'sd800) begin miss++; $display("FAIL walk467 got %0d want 800", bus.o_sprx); end
    repeat (10) @(posedge clk);
    #1;
    vec++; if (bus.o_sprx !== 16'sd800) begin miss++; $display("FAIL walk_hold got %0d want 800", bus.o_sprx); end
    bus.i_walk_en = 1'b0;
  endtask

  task automatic test_jump();
    do_reset();
    press();
    vec++; if (bus.o_state !== 2'd0) begin miss++; $display("FAIL jump_pre got %0d want 0", bus.o_state); end
    for (int f = 1; f <= 25; f++) begin
      frame();
      if (f == 1) begin vec++; if (bus.o_state !== 2'd1 || bus.o_airborne !== 1'b1 || bus.o_spry !== 16'sd240)
        begin miss++; $display("FAIL jump1 got st=%0d air=%0b y=%0d want 1/1/240", bus.o_state, bus.o_airborne, bus.o_spry); end end
      if (f == 2) begin vec++; if (bus.o_spry !== 16'sd228 || bus.o_base_addr !== 11'd640)
        begin miss++; $display("FAIL jump2 got y=%0d base=%0d want 228/640", bus.o_spry, bus.o_base_addr); end end
      if (f == 12) begin vec++; if (bus.o_state !== 2'd1 || bus.o_spry !== 16'sd163)
        begin miss++; $display("FAIL jump12 got st=%0d y=%0d want 1/163", bus.o_state, bus.o_spry); end end
      if (f == 13) begin vec++; if (bus.o_state !== 2'd2 || bus.o_spry !== 16'sd162 || bus.o_base_addr !== 11'd640)
        begin miss++; $display("FAIL jump13 got st=%0d y=%0d base=%0d want 2/162/640", bus.o_state, bus.o_spry, bus.o_base_addr); end end
      if (f == 24) begin vec++; if (bus.o_state !== 2'd2 || bus.o_spry !== 16'sd228)
        begin miss++; $display("FAIL jump24 got st=%0d y=%0d want 2/228", bus.o_state, bus.o_spry); end end
      if (f == 25) begin vec++; if (bus.o_state !== 2'd0 || bus.o_spry !== 16'sd240 || bus.o_airborne !== 1'b0 || bus.o_base_addr !== 11'd0)
        begin miss++; $display("FAIL jump25 got st=%0d y=%0d air=%0b base=%0d want 0/240/0/0", bus.o_state, bus.o_spry, bus.o_airborne, bus.o_base_addr); end end
    end
    vec++; if (bus.o_sprx !== 16'sd800) begin miss++; $display("FAIL jump_x got %0d want 800", bus.o_sprx); end
  endtask

  task automatic test_jump_airborne();
    do_reset();
    press();
    frame();
    press();
    repeat (24) frame();
    vec++; if (bus.o_state !== 2'd0 || bus.o_spry !== 16'sd240) begin miss++; $display("FAIL air_land got st=%0d y=%0d want 0/240", bus.o_state, bus.o_spry); end
    repeat (3) frame();
    vec++; if (bus.o_state !== 2'd0 || bus.o_spry !== 16'sd240) begin miss++; $display("FAIL air_nojump got st=%0d y=%0d want 0/240", bus.o_state, bus.o_spry); end
  endtask

  task automatic test_same_cycle();
    do_reset();
    @(posedge clk); #1 bus.i_jump_n = 1'b0;
    @(posedge clk);
    @(posedge clk); #1 bus.i_frame = 1'b1;
    @(posedge clk); #1 bus.i_frame = 1'b0;
    vec++; if (bus.o_state !== 2'd0 || bus.o_sprx !== 16'sd800) begin miss++; $display("FAIL same_frame got st=%0d x=%0d want 0/800", bus.o_state, bus.o_sprx); end
    repeat (4) @(posedge clk);
    #1 bus.i_jump_n = 1'b1;
    frame();
    vec++; if (bus.o_state !== 2'd1 || bus.o_sprx !== 16'sd800) begin miss++; $display("FAIL same_next got st=%0d x=%0d want 1/800", bus.o_state, bus.o_sprx); end
    repeat (30) frame();
  endtask

  task automatic test_async_reset();
    do_reset();
    bus.i_walk_en = 1'b1;
    press();
    repeat (5) frame();
    vec++; if (bus.o_airborne !== 1'b1 || bus.o_sprx !== 16'sd790 || bus.o_base_addr !== 11'd640)
      begin miss++; $display("FAIL mid_pre got air=%0b x=%0d base=%0d want 1/790/640", bus.o_airborne, bus.o_sprx, bus.o_base_addr); end
    @(posedge clk); #3 rst_n = 1'b0;
    #1;
    vec++; if (bus.o_sprx !== 16'sd800 || bus.o_spry !== 16'sd240 || bus.o_base_addr !== 11'd0 || bus.o_state !== 2'd0 || bus.o_airborne !== 1'b0)
      begin miss++; $display("FAIL mid_rst got x=%0d y=%0d base=%0d st=%0d air=%0b want 800/240/0/0/0", bus.o_sprx, bus.o_spry, bus.o_base_addr, bus.o_state, bus.o_airborne); end
    bus.i_walk_en = 1'b0;
    #3 rst_n = 1'b1;
  endtask

  initial begin
    bus.i_frame = 1'b0;
    bus.i_walk_en = 1'b0;
    bus.i_jump_n = 1'b1;
    test_reset();
    test_anim();
    test_walk_wrap();
    test_jump();
    test_jump_airborne();
    test_same_cycle();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule

// File: doc/sprite_motion.md
Name: sprite_motion

Overview:
Per-frame motion and animation controller for a walking/jumping sprite. It runs on the pixel clock and updates once per video frame on the frame-start pulse from the display timing generator. It produces the sprite's screen position (sprx, spry) and the graphic-ROM frame base address consumed by the sprite line engine and its ROM. Walk is gated by a switch; jump is triggered by a push-button with a parabolic trajectory.

Parameters:
CORDW, 16, signed screen coordinate width
ADDRW, 11, sprite ROM address width
SPR_PIXELS, 640, pixels per animation frame (32x20)
H_RES, 800, horizontal respawn x
WRAP_LEFT, -132, left limit; at or below this, x respawns at H_RES
SPEED_X, 2, pixels moved left per frame while walking
GROUND_Y, 240, resting y
JUMP_V0, 12, initial upward velocity (pixels/frame)
GRAVITY, 1, velocity change per frame
ANIM_STEP, 16, frames per animation phase (four phases)

Ports:
i_clk  in  1  pixel clock
i_rst_n  in  1  asynchronous active-low reset
i_frame  in  1  one-cycle pulse at frame start
i_walk_en  in  1  level; 1 = walk left
i_jump_n  in  1  raw push-button, active-low, asynchronous
o_sprx  out  CORDW signed  sprite x
o_spry  out  CORDW signed  sprite y
o_base_addr  out  ADDRW  ROM base of current animation frame
o_airborne  out  1  1 while in RISE or FALL
o_state  out  2  FSM state (GROUND=0, RISE=1, FALL=2)

Behaviour:
- Reset (async, any time, including mid-jump) sets: o_sprx=H_RES, o_spry=GROUND_Y, o_base_addr=0, state GROUND, vel=0, anim cnt=0, jump request=0, synchronizer flops=1.
- All outputs are registered. State updates only on cycles with i_frame=1, and outputs change on the following edge (1-cycle latency). Outputs hold between frame pulses.
- Button path: 2-flop synchronizer, then falling-edge detect, then sets a sticky jump request (req).
  - If req=1 at i_frame in GROUND: start jump and clear req.
  - If req=1 at i_frame in RISE/FALL: discard req (clear).
  - If an edge arrives in the same cycle as a clear, set wins.
- Horizontal motion, per frame with i_walk_en=1: o_sprx <= (o_sprx > WRAP_LEFT) ? o_sprx-SPEED_X : H_RES. With i_walk_en=0, o_sprx holds. Horizontal motion is independent of the jump FSM.
- Jump FSM, per frame:
  - GROUND: when req, go to RISE with vel=JUMP_V0. No y change on this frame.
  - RISE: spry <= spry-vel. If vel <= GRAVITY, set vel=0 and go to FALL; otherwise vel <= vel-GRAVITY.
  - FALL: v' = vel+GRAVITY. If spry+v' >= GROUND_Y, set spry=GROUND_Y, vel=0, and go to GROUND; otherwise spry <= spry+v', vel <= v'.
  - vel is 8-bit unsigned. y arithmetic is signed CORDW.
- Animation:
  - cnt is a 6-bit wrapping counter, incremented on frames where i_walk_en=1 and state=GROUND.
  - Base is selected from cnt before the increment: 0 gives 0; STEP-1 gives SPR_PIXELS; 2*STEP-1 gives 0; 3*STEP-1 gives 2*SPR_PIXELS. Other values hold.
  - Airborne: base is forced to SPR_PIXELS and cnt holds.
  - On landing, base returns to 0 on the landing frame and cnt resets to 0.
  - Walk disabled on ground: base is forced to 0 and cnt holds.

Decomposition:
- sprite_pkg: motion_state_t enum (GROUND, RISE, FALL) and CORDW default, shared with the sprite top.
- Sub-module key_sync_edge: 2-flop synchronizer plus falling-edge pulse, with async active-low reset to the released state.

Test Plan:
- Reset: assert i_rst_n=0 mid-jump, asynchronously, not on a clock edge. Required: outputs immediately 800/240/0, o_state=0, o_airborne=0.
- Walk wrap: i_walk_en=1, 466 frame pulses. Required: o_sprx=-132 after frame 466, 800 after frame 467, held while no i_frame.
- Animation: walk from reset. Required: base=640 after the 16th frame, 0 after the 32nd, 1280 after the 48th, 0 after the 65th.
- Jump: pulse i_jump_n low for 5 clocks, then frames. Required: RISE after frame 1, spry=162 with state FALL after frame 13, spry=240 with GROUND after frame 25, base=640 while airborne.
- Jump while airborne: second press during RISE. Required: ignored, no re-jump after landing.
- Same-cycle edge and i_frame with walk disabled: o_sprx constant. Jump starts no later than the second following frame.
